// File: rtl/i2s_nmi_pkg.sv
// Shared definitions for the I2S transmitter with NMI-style register port.
// Holds the register index enum, CTRL/STATUS bit positions, parameter
// defaults and a byte-strobe merge helper.
package i2s_nmi_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_DIV_W      = 8;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_idx_e;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_DIV_LSB = 8;

  // STATUS bit positions
  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_EMPTY     = 5;
  localparam int STAT_FULL      = 6;
  localparam int STAT_UNDERRUN  = 8;
  localparam int STAT_OVERFLOW  = 9;

  // Slots per stereo frame (16 left + 16 right)
  localparam int SLOT_W = 5;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/i2s_nmi_slv_fifo.sv
// i2s_fifo: synchronous FIFO of stereo sample words.
// Ports: clk_i/rst_i (async active-high), push_i/data_i write side,
// pop_i/data_o read side (data_o shows the head word), full_o, empty_o,
// level_o (number of stored words, 0..DEPTH).
// Pushes while full and pops while empty are ignored.
module i2s_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    full_o  = (count_q == (AW+1)'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count decides which entries are valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/i2s_nmi_slv.sv
// i2s_nmi_slv: I2S (Philips format) stereo transmitter behind a simple
// valid/ready memory port.
// Ports: clk_i, rst_i (async active-high); mem_valid_i/mem_addr_i/
// mem_wdata_i/mem_wstrb_i request, mem_rdata_o/mem_ready_o response;
// i2s_sck_o, i2s_ws_o, i2s_sd_o serial audio; irq_o level interrupt.
// Registers (addr[3:2]): CTRL, STATUS, DATA (FIFO push), reserved.
import i2s_nmi_pkg::*;

module i2s_nmi_slv #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        i2s_sck_o,
  output logic        i2s_ws_o,
  output logic        i2s_sd_o,
  output logic        irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Bus / register state
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;

  // Divider / serializer state
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              act_q, act_d;
  logic              sck_q, sck_d;
  logic              ws_q, ws_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              started_q, started_d;
  logic [31:0]       sr_q, sr_d;

  reg_idx_e         reg_idx;
  logic             is_wr, is_rd, data_wr;
  logic [31:0]      ctrl_img, status_img, rdata_sel, ctrl_new;
  logic             und_set, und_clr, ovf_set, ovf_clr;
  logic [DIV_W-1:0] cur;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]      fifo_head;
  logic [LVL_W-1:0] fifo_level;
  logic             unused_ok;

  i2s_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (mem_wdata_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Register port: the access is performed in the ready cycle, while the
  // initiator is still holding the request.
  always_comb begin
    reg_idx = reg_idx_e'(mem_addr_i[3:2]);
    ready_d = mem_valid_i & ~ready_q;
    is_wr   = ready_q & mem_valid_i & (mem_wstrb_i != 4'b0);
    is_rd   = ready_q & mem_valid_i & (mem_wstrb_i == 4'b0);

    ctrl_img = '0;
    ctrl_img[CTRL_EN]                 = en_q;
    ctrl_img[CTRL_IRQ_EN]             = irq_en_q;
    ctrl_img[CTRL_DIV_LSB +: DIV_W]   = div_q;

    status_img = '0;
    status_img[STAT_LEVEL_LSB +: LVL_W] = fifo_level;
    status_img[STAT_EMPTY]              = fifo_empty;
    status_img[STAT_FULL]               = fifo_full;
    status_img[STAT_UNDERRUN]           = underrun_q;
    status_img[STAT_OVERFLOW]           = overflow_q;

    case (reg_idx)
      REG_CTRL:   rdata_sel = ctrl_img;
      REG_STATUS: rdata_sel = status_img;
      default:    rdata_sel = '0;
    endcase

    ctrl_new = apply_wstrb(ctrl_img, mem_wdata_i, mem_wstrb_i);
    en_d     = en_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    if (is_wr && reg_idx == REG_CTRL) begin
      en_d     = ctrl_new[CTRL_EN];
      irq_en_d = ctrl_new[CTRL_IRQ_EN];
      div_d    = ctrl_new[CTRL_DIV_LSB +: DIV_W];
    end

    data_wr   = is_wr && reg_idx == REG_DATA;
    fifo_push = data_wr & ~fifo_full;
    ovf_set   = data_wr & fifo_full;

    und_clr = is_wr && reg_idx == REG_STATUS && mem_wstrb_i[1] && mem_wdata_i[STAT_UNDERRUN];
    ovf_clr = is_wr && reg_idx == REG_STATUS && mem_wstrb_i[1] && mem_wdata_i[STAT_OVERFLOW];

    // A new event in the same cycle as a clear wins, so nothing is lost
    underrun_d = (underrun_q & ~und_clr) | und_set;
    overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
  end

  // Divider and serializer. The divider counts down from DIV; on the first
  // enabled cycle it starts from the live DIV so the first rising sck edge
  // comes DIV+1 cycles after EN. Everything advances on sck falling edges.
  always_comb begin
    cnt_d     = cnt_q;
    act_d     = act_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    slot_d    = slot_q;
    started_d = started_q;
    sr_d      = sr_q;
    fifo_pop  = 1'b0;
    und_set   = 1'b0;
    cur       = act_q ? cnt_q : div_q;

    if (!en_q) begin
      cnt_d     = '0;
      act_d     = 1'b0;
      sck_d     = 1'b0;
      ws_d      = 1'b0;
      slot_d    = '0;
      started_d = 1'b0;
      sr_d      = '0;
    end else begin
      act_d = 1'b1;
      if (cur == '0) begin
        cnt_d = div_q;
        sck_d = ~sck_q;
        if (sck_q) begin
          // First falling edge after enable starts the frame at slot 0
          slot_d    = started_q ? slot_q + SLOT_W'(1) : '0;
          started_d = 1'b1;
          if (slot_d == '0) begin
            if (!fifo_empty) begin
              sr_d     = fifo_head;
              fifo_pop = 1'b1;
            end else begin
              sr_d    = '0;
              und_set = 1'b1;
            end
          end else begin
            sr_d = {sr_q[30:0], 1'b0};
          end
          // WS switches one slot ahead of each word's MSB
          ws_d = (slot_d >= SLOT_W'(15)) && (slot_d <= SLOT_W'(30));
        end
      end else begin
        cnt_d = cur - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      act_q      <= 1'b0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      slot_q     <= '0;
      started_q  <= 1'b0;
      sr_q       <= '0;
    end else begin
      ready_q    <= ready_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      div_q      <= div_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      slot_q     <= slot_d;
      started_q  <= started_d;
      sr_q       <= sr_d;
    end
  end

  // Gating with EN silences the serial pins in the very cycle EN drops;
  // the serializer state itself clears one cycle later.
  assign mem_ready_o = ready_q;
  assign mem_rdata_o = is_rd ? rdata_sel : '0;
  assign i2s_sck_o   = sck_q & en_q;
  assign i2s_ws_o    = ws_q & en_q;
  assign i2s_sd_o    = sr_q[31] & en_q;
  assign irq_o       = irq_en_q & (fifo_empty | underrun_q | overflow_q);

  // Address bits outside [3:2] and unimplemented CTRL bits are don't-care
  assign unused_ok = ^{mem_addr_i[31:4], mem_addr_i[1:0], ctrl_new};

endmodule

// File: doc/i2s_nmi_slv.md
I2S_NMI_SLV -- requirements
Module: i2s_nmi_slv

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving the number of 32-bit stereo samples buffered (power of two, 2..16).
REQ-002 SHALL have parameter DIV_W, default 8, giving the width of the bit-clock divider field.
REQ-003 clk_i  input  1  single (audio-domain) clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-005 mem_valid_i  input  1  NMI request valid; held by the initiator until ready.
REQ-006 mem_addr_i  input  32  byte address; only bits [3:2] are decoded.
REQ-007 mem_wdata_i  input  32  write data.
REQ-008 mem_wstrb_i  input  4  byte strobes; a nonzero value means write, zero means read.
REQ-009 mem_rdata_o  output  32  read data, valid while mem_ready_o=1.
REQ-010 mem_ready_o  output  1  one-cycle completion pulse.
REQ-011 i2s_sck_o  output  1  I2S bit clock.
REQ-012 i2s_ws_o  output  1  word select: 0 = left, 1 = right.
REQ-013 i2s_sd_o  output  1  serial data, MSB first.
REQ-014 irq_o  output  1  level interrupt.

Function
REQ-015 Registers, decoded from addr[3:2]:
- 0 CTRL: bit0 EN, bit1 IRQ_EN, [8+DIV_W-1:8] DIV.
- 1 STATUS: [4:0] LEVEL, bit5 EMPTY, bit6 FULL, bit8 UNDERRUN, bit9 OVERFLOW.
- 2 DATA: write-only; [31:16] left, [15:0] right.
- 3 reserved: reads 0, writes ignored.
REQ-016 Handshake: mem_ready_o SHALL pulse high exactly one cycle after the first cycle mem_valid_i=1, and never on two consecutive cycles; a valid still high in the cycle after ready is treated as a new request.
REQ-017 Reads SHALL return the register value sampled in the ready cycle; DATA reads SHALL return 0; mem_rdata_o SHALL be 0 when mem_ready_o=0.
REQ-018 CTRL writes SHALL honour byte strobes.
REQ-019 STATUS writes SHALL clear UNDERRUN and OVERFLOW where the written bit is 1 (write-1-to-clear); all other STATUS bits are read-only.
REQ-020 A DATA write with any nonzero strobe SHALL push the full word when the FIFO is not full.
REQ-021 A DATA write when the FIFO is full SHALL drop the word, set OVERFLOW, and still complete with ready.
REQ-022 A push and a pop in the same cycle SHALL leave LEVEL unchanged; a push into an empty FIFO SHALL become visible to the serializer on the next cycle.
REQ-023 Bit-clock divider: while EN=1, a counter SHALL toggle i2s_sck_o every DIV+1 clk cycles (DIV=0 gives sck = clk/2).
REQ-024 Outputs change only on sck falling edges (the toggle 1->0).
REQ-025 Slot counter b SHALL run 0..31, advance on each sck falling edge, and wrap 31->0.
REQ-026 Left bits SHALL be driven on b=0..15 and right bits on b=16..31.
REQ-027 i2s_ws_o SHALL be 1 for b=15..30 and 0 otherwise, so WS leads each word MSB by one bit (Philips format).
REQ-028 On each falling edge that enters b=0, the shift register SHALL load the FIFO head and pop it.
REQ-029 If the FIFO is empty when entering b=0, the shift register SHALL load 0 and set UNDERRUN.
REQ-030 The first frame after EN rises SHALL start at b=0 on the first sck falling edge, which occurs 2*(DIV+1) cycles after the EN write.
REQ-031 EN=0 SHALL immediately force sck, ws and sd to 0 and clear the divider, slot counter and shift register; FIFO contents and sticky bits are kept. Clearing EN mid-frame aborts the frame with no further pops.
REQ-032 A DIV change while EN=1 SHALL take effect at the next divider reload.
REQ-033 irq_o = IRQ_EN & (EMPTY | UNDERRUN | OVERFLOW).

Reset
REQ-034 During and after reset: CTRL=0, FIFO empty, UNDERRUN=OVERFLOW=0, all counters 0, and every output (mem_ready_o, mem_rdata_o, i2s_sck_o, i2s_ws_o, i2s_sd_o, irq_o) = 0.
REQ-035 A reset asserted mid-transaction or mid-frame SHALL abandon the transaction or frame without emitting a ready pulse.

Structure
REQ-036 Package i2s_nmi_pkg SHALL hold the register index constants, CTRL/STATUS bit positions, and the FIFO_DEPTH/DIV_W defaults.
REQ-037 The FIFO SHALL be a separate sub-module i2s_fifo (synchronous; push/pop/full/empty/level); the register file, divider and serializer live in i2s_nmi_slv.

Verification
REQ-038 Reset -> all outputs 0; STATUS read returns 0x20 (EMPTY only).
REQ-039 Write DATA=0xA5A5_0F0F, then CTRL=0x0301 (DIV=3, EN) -> sck period 8 clk; frame carries left 0xA5A5 on b=0..15 and right 0x0F0F on b=16..31; ws rises at b=15; UNDERRUN=0 after the first frame.
REQ-040 EN with an empty FIFO -> sd stays 0 and UNDERRUN=1; STATUS write 0x100 -> UNDERRUN=0 while still empty.
REQ-041 Nine DATA writes with EN=0 (FIFO_DEPTH=8) -> LEVEL=8, FULL=1, OVERFLOW=1, the ninth word is absent, and every write receives exactly one ready pulse.
REQ-042 Clear EN at b=20 -> sck/ws/sd are 0 on the next cycle and LEVEL is unchanged; re-enable -> the next frame starts with the next FIFO word at b=0.
REQ-043 A push in the same cycle as a pop at b=0 with LEVEL=1 -> LEVEL remains 1; IRQ_EN=1 with an empty FIFO -> irq_o=1.
